dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised, byte-addressable data memory for the MIPS core's MEM stage. It supports byte, halfword and word loads and stores with sign or zero extension. Accesses use a req/ready handshake with a configurable number of wait states, and the memory is cleared by a hardware sweep after reset. The block replaces the single-cycle word-only data memory and keeps a 16-bit debug mirror for board display.

## Interface
- WIDTH, 32, data and address width; fixed lane layout of 4 bytes.
- DEPTH, 256, number of words; power of two, 4..4096.
- WAIT, 1, wait states between accept and response; 0..15.
- TEST_ADDR, 0, word index mirrored onto test_value.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request, sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- unsigned_ld  in  1  1 = zero-extend loads, 0 = sign-extend.
- A  in  WIDTH  byte address.
- WD  in  WIDTH  store data; byte and half stores take the low bits.
- RD  out  WIDTH  load data, valid while ready=1.
- ready  out  1  one-cycle response pulse.
- busy  out  1  high in every state except IDLE.
- misalign  out  1  high with ready for a rejected misaligned access.
- test_value  out  16  registered low half of word TEST_ADDR.

## Operation
- States: INIT, IDLE, WAIT, RESP.
- INIT: a counter clears one word per cycle, index 0..DEPTH-1, then the block moves to IDLE. It lasts exactly DEPTH cycles and busy=1 throughout.
- IDLE: when req=1, the block latches A, WD, we, size and unsigned_ld. It goes to WAIT if WAIT>0, otherwise to RESP.
- WAIT: a down-counter runs WAIT cycles, then the block goes to RESP.
- RESP: ready=1 for exactly one cycle, then the block returns to IDLE. req is ignored in RESP, WAIT and INIT and is not queued.
- Word index = A[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·DEPTH bytes.
- Stores write only the selected lanes:
  - byte: lane A[1:0] gets WD[7:0].
  - half: lanes {A[1],1},{A[1],0} get WD[15:0].
  - word: all lanes.
- Loads: the selected byte or half is right-justified, then extended per unsigned_ld. Word loads are passed unmodified.
- Misaligned access: half with A[0]=1, or word with A[1:0]≠0. Handling depends on the Configuration section.

## Timing
- Reset values: RD=0, ready=0, misalign=0, test_value=0, busy=1, state=INIT, counters=0.
- rst asserted in any state aborts the access in progress and restarts INIT. A store due to commit at the same edge is dropped; rst wins.
- Accept at edge k; the store commits and RD is registered at edge k+WAIT+1; ready is high during cycle k+WAIT+1.
- Throughput is one access per WAIT+2 cycles.
- RD holds its value after ready falls until the next response.
- test_value updates one cycle after a write to TEST_ADDR commits.
- An access issued during INIT is ignored and produces no ready pulse.

## Configuration
- DMEM_MISALIGN_EXC_EN defined:
  - A misaligned access performs no write and returns RD=0.
  - It pulses ready with misalign=1 at the normal latency.
- DMEM_MISALIGN_EXC_EN undefined:
  - The low address bits are forced aligned (half clears A[0]; word clears A[1:0]).
  - The access proceeds normally; misalign is tied 0.

## Structure
- dmem_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum and the lane-count constant.
- Sub-module dmem_load_align is combinational. It takes the raw word, A[1:0], size and unsigned_ld, and produces the extended RD value. It is reused by the store lane-mask generator.

## Test plan
- Reset, then hold rst=0 with DEPTH=256 → busy=1 for 256 cycles; a word load of every address returns 0.
- Word store 0xDEADBEEF @0x10, then byte load @0x13 signed, WAIT=1 → RD=0xFFFFFFDE, ready 2 cycles after accept.
- Same word, half load @0x12 unsigned → RD=0x0000DEAD; byte store 0x5A @0x11, then word load → 0xDEAD5AEF.
- Word store @0x06 with the macro defined → misalign=1, RD=0, memory unchanged. Without the macro → word @0x04 written.
- req held high continuously with WAIT=0 → one ready every 2 cycles; stores to TEST_ADDR show 0xBEEF on test_value the cycle after commit.
- rst asserted in the WAIT state of a store → no ready pulse, INIT restarts, and the stored word reads 0 afterwards.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-addressable data memory controller.
package dmem_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Size code 11 behaves as a word access everywhere downstream.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_WORD : sz;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Lane selection for loads (right-justify and extend) and the matching store lane mask.
module dmem_load_align
    import dmem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]     word_i,
    input  logic [1:0]           off_i,
    input  logic [1:0]           size_i,
    input  logic                 unsigned_i,
    output logic [WIDTH-1:0]     rd_o,
    output logic [NUM_LANES-1:0] lane_mask_o
);

    localparam int LW = WIDTH / NUM_LANES;

    logic [LW-1:0]   byte_v;
    logic [2*LW-1:0] half_v;

    always_comb begin
        case (off_i)
            2'd0:    byte_v = word_i[LW-1:0];
            2'd1:    byte_v = word_i[2*LW-1:LW];
            2'd2:    byte_v = word_i[3*LW-1:2*LW];
            default: byte_v = word_i[WIDTH-1:3*LW];
        endcase
        half_v = off_i[1] ? word_i[WIDTH-1:2*LW] : word_i[2*LW-1:0];
    end

    always_comb begin
        rd_o        = word_i;
        lane_mask_o = 4'b1111;
        case (size_i)
            SZ_BYTE: begin
                rd_o        = unsigned_i ? {{(WIDTH-LW){1'b0}}, byte_v}
                                         : {{(WIDTH-LW){byte_v[LW-1]}}, byte_v};
                lane_mask_o = 4'b0001 << off_i;
            end
            SZ_HALF: begin
                rd_o        = unsigned_i ? {{(WIDTH-2*LW){1'b0}}, half_v}
                                         : {{(WIDTH-2*LW){half_v[2*LW-1]}}, half_v};
                lane_mask_o = off_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                rd_o        = word_i;
                lane_mask_o = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory with byte/half/word access, wait-state handshake and post-reset clear sweep.
// Define DMEM_MISALIGN_EXC_EN to reject misaligned accesses instead of force-aligning them.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 256,
    parameter int WAIT      = 1,
    parameter int TEST_ADDR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [1:0]       size,
    input  logic             unsigned_ld,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] WD,
    output logic [WIDTH-1:0] RD,
    output logic             ready,
    output logic             busy,
    output logic             misalign,
    output logic [15:0]      test_value
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 4;
    localparam int LW = WIDTH / NUM_LANES;
    localparam logic [AW-1:0] TADDR = AW'(TEST_ADDR);

    logic [WIDTH-1:0] mem_q [DEPTH];

    state_t           state_q;
    logic [AW-1:0]    init_idx_q;
    logic [CW-1:0]    wait_cnt_q;
    logic [AW-1:0]    idx_q;
    logic [1:0]       off_q;
    logic [1:0]       sz_q;
    logic             we_q;
    logic             uns_q;
    logic             mis_q;
    logic [WIDTH-1:0] wd_q;
    logic [WIDTH-1:0] rd_q;
    logic             ready_q;
    logic             busy_q;
    logic             misalign_q;
    logic [15:0]      test_value_q;

    logic [1:0]       req_sz;
    logic [1:0]       req_off;
    logic             req_mis;
    logic             unused_addr_bits;

    logic [WIDTH-1:0]     cur_word;
    logic [WIDTH-1:0]     rd_ext;
    logic [WIDTH-1:0]     wd_lanes;
    logic [WIDTH-1:0]     st_word;
    logic [NUM_LANES-1:0] lane_mask;
    logic                 mem_we;
    logic [AW-1:0]        mem_waddr;
    logic [WIDTH-1:0]     mem_wdata;

    assign unused_addr_bits = ^A[WIDTH-1:AW+2];

    always_comb begin
        req_sz  = norm_size(size);
        req_off = A[1:0];
        req_mis = 1'b0;
`ifdef DMEM_MISALIGN_EXC_EN
        if (req_sz == SZ_HALF) begin
            req_mis = A[0];
        end else if (req_sz == SZ_WORD) begin
            req_mis = |A[1:0];
        end
`else
        if (req_sz == SZ_HALF) begin
            req_off[0] = 1'b0;
        end else if (req_sz == SZ_WORD) begin
            req_off = 2'b00;
        end
`endif
    end

    assign cur_word = mem_q[idx_q];

    dmem_load_align #(
        .WIDTH(WIDTH)
    ) u_align (
        .word_i      (cur_word),
        .off_i       (off_q),
        .size_i      (sz_q),
        .unsigned_i  (uns_q),
        .rd_o        (rd_ext),
        .lane_mask_o (lane_mask)
    );

    always_comb begin
        case (sz_q)
            SZ_BYTE: wd_lanes = {NUM_LANES{wd_q[LW-1:0]}};
            SZ_HALF: wd_lanes = {(NUM_LANES/2){wd_q[2*LW-1:0]}};
            default: wd_lanes = wd_q;
        endcase
        st_word = cur_word;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_mask[l]) begin
                st_word[l*LW +: LW] = wd_lanes[l*LW +: LW];
            end
        end
    end

    // Single write port shared by the clear sweep and store commit; reset blocks both.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = init_idx_q;
            end else if (state_q == ST_RESP && we_q && !mis_q) begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = st_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            wait_cnt_q <= '0;
            idx_q      <= '0;
            off_q      <= '0;
            sz_q       <= SZ_BYTE;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            mis_q      <= 1'b0;
            wd_q       <= '0;
            rd_q       <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            misalign_q <= 1'b0;
        end else begin
            ready_q    <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    init_idx_q <= init_idx_q + AW'(1);
                    if (init_idx_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (req) begin
                        idx_q  <= A[AW+1:2];
                        off_q  <= req_off;
                        sz_q   <= req_sz;
                        we_q   <= we;
                        uns_q  <= unsigned_ld;
                        mis_q  <= req_mis;
                        wd_q   <= WD;
                        busy_q <= 1'b1;
                        if (WAIT > 0) begin
                            state_q    <= ST_WAIT;
                            wait_cnt_q <= CW'(WAIT - 1);
                        end else begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CW'(1);
                    end
                end
                ST_RESP: begin
                    ready_q    <= 1'b1;
                    misalign_q <= mis_q;
                    rd_q       <= mis_q ? '0 : rd_ext;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Mirror lags a commit by one cycle because it samples the array contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            test_value_q <= '0;
        end else begin
            test_value_q <= mem_q[TADDR][15:0];
        end
    end

    assign RD         = rd_q;
    assign ready      = ready_q;
    assign busy       = busy_q;
    assign misalign   = misalign_q;
    assign test_value = test_value_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: byte-array reference model plus directed and random stimulus.
module tb_dmem_ctrl;

    localparam int DEPTH = 256;
    localparam int W     = 1;
    localparam int TA    = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        unsigned_ld = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] WD = '0;
    logic [31:0] RD;
    logic        ready;
    logic        busy;
    logic        misalign;
    logic [15:0] test_value;

    int n_chk = 0;
    int n_fail = 0;

    dmem_ctrl #(
        .WIDTH(32), .DEPTH(DEPTH), .WAIT(W), .TEST_ADDR(TA)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size),
        .unsigned_ld(unsigned_ld), .A(A), .WD(WD), .RD(RD), .ready(ready),
        .busy(busy), .misalign(misalign), .test_value(test_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mmem [4*DEPTH];
    int          cyc = 0;
    int          init_left = DEPTH;
    bit          pend = 0;
    int          resp_at = 0;
    bit          p_we, p_uns;
    logic [1:0]  p_size;
    logic [31:0] p_addr, p_wd;
    bit          e_ready = 0, e_busy = 1, e_mis = 0, rd_known = 1;
    logic [31:0] e_rd = '0;
    logic [15:0] e_tv = '0;
    bit          chk_en = 0;

    task automatic model_access();
        int a, n;
        logic [31:0] v;
        a = int'(p_addr % (4*DEPTH));
        n = (p_size == 2'd0) ? 1 : (p_size == 2'd1) ? 2 : 4;
        e_ready = 1;
`ifdef DMEM_MISALIGN_EXC_EN
        if ((a % n) != 0) begin
            e_mis = 1;
            e_rd = '0;
            rd_known = 1;
            return;
        end
`endif
        a = a - (a % n);
        if (p_we) begin
            for (int i = 0; i < n; i++) mmem[a+i] = p_wd[8*i +: 8];
            rd_known = 0;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mmem[a+i];
            if (!p_uns && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!p_uns && n == 2) v = {{16{v[15]}}, v[15:0]};
            e_rd = v;
            rd_known = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        e_tv = {mmem[4*TA+1], mmem[4*TA]};
        if (rst) begin
            init_left = DEPTH;
            pend = 0;
            e_ready = 0; e_mis = 0; e_rd = '0; rd_known = 1; e_tv = '0;
            for (int i = 0; i < 4*DEPTH; i++) mmem[i] = 8'h00;
            chk_en = 1;
        end else begin
            e_ready = 0;
            e_mis = 0;
            if (init_left > 0) begin
                init_left--;
            end else if (pend) begin
                if (cyc == resp_at) begin
                    model_access();
                    pend = 0;
                end
            end else if (req) begin
                pend = 1;
                resp_at = cyc + W + 1;
                p_we = we; p_uns = unsigned_ld; p_addr = A; p_wd = WD;
                p_size = (size == 2'b11) ? 2'b10 : size;
            end
        end
        e_busy = (init_left > 0) || pend;
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("ready", {31'b0, ready}, {31'b0, e_ready});
            chk("busy", {31'b0, busy}, {31'b0, e_busy});
            chk("misalign", {31'b0, misalign}, {31'b0, e_mis});
            if (rd_known) chk("RD", RD, e_rd);
            if (init_left == 0) chk("test_value", {16'b0, test_value}, {16'b0, e_tv});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_acc(input bit w, input logic [1:0] sz, input bit u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd_o, output bit mis_o, output int lat);
        @(negedge clk);
        req = 1; we = w; size = sz; unsigned_ld = u; A = a; WD = d;
        @(posedge clk);
        #1 req = 0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!ready && lat < 40);
        chk("acc_ready_seen", {31'b0, ready}, 32'd1);
        rd_o = RD;
        mis_o = misalign;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy && k < 1000) begin
            @(posedge clk);
            #1 k++;
        end
        chk(nm, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          mis;
        int          lat, cnt, last, nrdy;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_RD", RD, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_test_value", {16'b0, test_value}, 32'd0);

        @(negedge clk);
        rst = 0;
        cnt = 0;
        do begin
            @(posedge clk);
            #1 cnt++;
        end while (busy && cnt < 1000);
        chk("init_busy_cycles", 32'(cnt), 32'd256);

        for (int i = 0; i < DEPTH; i++) begin
            do_acc(0, 2'b10, 0, 32'(i*4), 32'h0, rd, mis, lat);
            chk("cleared_word", rd, 32'h0);
        end

        do_acc(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, mis, lat);
        do_acc(0, 2'b00, 0, 32'h13, 32'h0, rd, mis, lat);
        chk("lb_signed_13", rd, 32'hFFFFFFDE);
        chk("latency", 32'(lat), 32'd2);
        do_acc(0, 2'b01, 1, 32'h12, 32'h0, rd, mis, lat);
        chk("lhu_12", rd, 32'h0000DEAD);
        do_acc(0, 2'b01, 0, 32'h12, 32'h0, rd, mis, lat);
        chk("lh_signed_12", rd, 32'hFFFFDEAD);
        do_acc(1, 2'b00, 0, 32'h11, 32'hFFFFFF5A, rd, mis, lat);
        do_acc(0, 2'b10, 0, 32'h10, 32'h0, rd, mis, lat);
        chk("lw_after_sb", rd, 32'hDEAD5AEF);
        do_acc(0, 2'b00, 1, 32'h11, 32'h0, rd, mis, lat);
        chk("lbu_11", rd, 32'h0000005A);
        do_acc(0, 2'b11, 0, 32'h0001_0410, 32'h0, rd, mis, lat);
        chk("wrap_size11", rd, 32'hDEAD5AEF);

        do_acc(1, 2'b10, 0, 32'h06, 32'hCAFEF00D, rd, mis, lat);
`ifdef DMEM_MISALIGN_EXC_EN
        chk("mis_flag", {31'b0, mis}, 32'd1);
        chk("mis_rd", rd, 32'h0);
        do_acc(0, 2'b10, 0, 32'h04, 32'h0, rd, mis, lat);
        chk("mis_nowrite", rd, 32'h0);
`else
        chk("mis_flag", {31'b0, mis}, 32'd0);
        do_acc(0, 2'b10, 0, 32'h04, 32'h0, rd, mis, lat);
        chk("forced_align_write", rd, 32'hCAFEF00D);
`endif

        do_acc(1, 2'b10, 0, 32'(TA*4), 32'h1111BEEF, rd, mis, lat);
        chk("tv_before", {16'b0, test_value}, 32'h0);
        @(posedge clk);
        #1 chk("tv_after_commit", {16'b0, test_value}, 32'h0000BEEF);

        @(negedge clk);
        req = 1; we = 1; size = 2'b10; unsigned_ld = 0; A = 32'(TA*4); WD = 32'h2222CAFE;
        last = -1;
        nrdy = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                if (last >= 0) chk("thru_gap", 32'(c - last), 32'(W + 2));
                last = c;
                nrdy++;
            end
        end
        chk("thru_count_ok", {31'b0, nrdy >= 5}, 32'd1);
        @(negedge clk);
        req = 0;
        repeat (6) @(posedge clk);
        #1 chk("tv_held_req", {16'b0, test_value}, 32'h0000CAFE);

        @(negedge clk);
        req = 1; we = 1; size = 2'b10; A = 32'h20; WD = 32'h12345678;
        @(posedge clk);
        #1 req = 0; rst = 1;
        @(posedge clk);
        #1 chk("abort_no_ready1", {31'b0, ready}, 32'd0);
        @(posedge clk);
        #1 chk("abort_no_ready2", {31'b0, ready}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        rst = 0;
        wait_idle("abort_init_done");
        do_acc(0, 2'b10, 0, 32'h20, 32'h0, rd, mis, lat);
        chk("abort_store_dropped", rd, 32'h0);
        do_acc(0, 2'b10, 0, 32'h10, 32'h0, rd, mis, lat);
        chk("abort_mem_cleared", rd, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            req = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            unsigned_ld = 1'($urandom_range(0, 1));
            A = ($urandom() & 32'hFFFF_FC00) |
                32'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 47) : $urandom_range(0, 1023));
            WD = $urandom();
        end
        @(negedge clk);
        rst = 0;
        req = 0;
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
